// File: rtl/r5p_soc_loader_pkg.sv
// Shared types for the memory loader: FSM states, word assembly and TCB-Lite payloads.
package r5p_soc_loader_pkg;

    localparam int unsigned HDR_LEN = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DAT,
        S_WR,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [31:0] wdt;
        logic [3:0]  byt;
    } word_asm_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  byt;
        logic [31:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [31:0] rdt;
        logic        err;
    } tcb_rsp_t;

endpackage

// File: rtl/tcb_lite_if.sv
// TCB-Lite bus bundle: valid/ready handshake, request payload, delayed response.
interface tcb_lite_if (
    input logic clk
);

    logic                         vld;
    logic                         rdy;
    r5p_soc_loader_pkg::tcb_req_t req;
    r5p_soc_loader_pkg::tcb_rsp_t rsp;

    modport man (input clk, output vld, output req, input rdy, input rsp);
    modport sub (input clk, input vld, input req, output rdy, output rsp);

endinterface

// File: rtl/r5p_soc_loader_pack.sv
// Lane-steering byte packer: drops each strobed byte into its lane and marks the lane valid.
module r5p_soc_loader_pack
    import r5p_soc_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        stb,
    input  logic [1:0]  lane,
    input  logic [7:0]  dat,
    output logic [31:0] word,
    output logic [3:0]  mask
);

    word_asm_t asm_q;

    // clear zeroes the data too so lanes never written read back as 0
    always_ff @(posedge clk) begin
        if (clr) begin
            asm_q <= '0;
        end else if (stb) begin
            asm_q.wdt[{lane, 3'b000} +: 8] <= dat;
            asm_q.byt[lane]                <= 1'b1;
        end
    end

    assign word = asm_q.wdt;
    assign mask = asm_q.byt;

endmodule

// File: rtl/r5p_soc_memory_loader.sv
// Boot/debug loader: turns a framed byte stream (ADR, LEN, payload) into TCB-Lite memory writes.
module r5p_soc_memory_loader
    import r5p_soc_loader_pkg::*;
#(
    parameter int unsigned DLY = 1,
    parameter int unsigned DAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd_vld,
    output logic        rxd_rdy,
    input  logic [7:0]  rxd_dat,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] sum,
    tcb_lite_if.man     man
);

    if (DAT != 32) begin : g_dat_chk
        $fatal(1, "r5p_soc_memory_loader: only DAT=32 is supported");
    end
    if (DLY < 1) begin : g_dly_chk
        $fatal(1, "r5p_soc_memory_loader: DLY must be at least 1");
    end

    state_t           state;
    logic [2:0]       hidx;
    logic [31:0]      adr;
    logic [31:0]      cnt;
    logic [29:0]      wadr;
    logic             vld;
    logic [DLY-1:0]   pipe;
    logic [31:0]      word;
    logic [3:0]       mask;

    logic             rxd_trn;
    logic             trn;
    logic             start;
    logic             pk_stb;
    logic             pk_clr;
    logic [31:0]      len_nxt;

    assign rxd_trn = rxd_vld & rxd_rdy;
    assign trn     = vld & man.rdy;
    assign start   = (state == S_IDLE) && rxd_trn;
    assign pk_stb  = (state == S_DAT) && rxd_trn;
    assign pk_clr  = rst || start || ((state == S_WR) && trn);
    // LEN is the last four header bytes shifted in little-endian
    assign len_nxt = {rxd_dat, cnt[31:8]};

    r5p_soc_loader_pack u_pack (
        .clk  (clk),
        .clr  (pk_clr),
        .stb  (pk_stb),
        .lane (adr[1:0]),
        .dat  (rxd_dat),
        .word (word),
        .mask (mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            hidx    <= '0;
            rxd_rdy <= 1'b0;
            vld     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            sum     <= '0;
            pipe    <= '0;
        end else begin
            pipe <= (pipe << 1) | DLY'(trn);
            if (pipe[DLY-1] && man.rsp.err) begin
                err <= 1'b1;
            end
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    rxd_rdy <= 1'b1;
                    if (rxd_trn) begin
                        state <= S_HDR;
                        hidx  <= 3'd1;
                        err   <= 1'b0;
                        sum   <= '0;
                    end
                end
                S_HDR: begin
                    if (rxd_trn) begin
                        hidx <= hidx + 3'd1;
                        if (hidx == 3'(HDR_LEN - 1)) begin
                            if (len_nxt == 32'd0) begin
                                state   <= S_FIN;
                                rxd_rdy <= 1'b0;
                            end else begin
                                state <= S_DAT;
                            end
                        end
                    end
                end
                S_DAT: begin
                    if (rxd_trn) begin
                        sum <= sum + {24'h0, rxd_dat};
                        if ((adr[1:0] == 2'd3) || (cnt == 32'd1)) begin
                            state   <= S_WR;
                            rxd_rdy <= 1'b0;
                            vld     <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (trn) begin
                        vld <= 1'b0;
                        if (cnt == 32'd0) begin
                            state <= S_FIN;
                        end else begin
                            state   <= S_DAT;
                            rxd_rdy <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    // done is raised while still in FIN so it never meets a new frame's first byte
                    if (done) begin
                        state   <= S_IDLE;
                        rxd_rdy <= 1'b1;
                    end else if (pipe == '0) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rxd_rdy <= 1'b0;
                    vld     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rxd_trn && ((state == S_IDLE) || (state == S_HDR))) begin
            if ((state == S_IDLE) || (hidx < 3'd4)) begin
                adr <= {rxd_dat, adr[31:8]};
            end else begin
                cnt <= len_nxt;
            end
        end
        if (pk_stb) begin
            wadr <= adr[31:2];
            adr  <= adr + 32'd1;
            cnt  <= cnt - 32'd1;
        end
    end

    assign busy    = (state != S_IDLE) || (pipe != '0);
    assign man.vld = vld;
    assign man.req = tcb_req_t'{
        ren: 1'b0,
        wen: 1'b1,
        adr: {wadr, 2'b00},
        byt: mask,
        wdt: word
    };

endmodule
